// File: rtl/shader_pkg.sv
// Instruction word layout, opcodes and issuer state encoding.
// Shared with the shader_core decoder.
package shader_pkg;

   localparam int INSTR_W = 16;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_XOR  = 3'd4,
      OP_MUL  = 3'd5,
      OP_RSV6 = 3'd6,
      OP_HALT = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // {op[15:13], rs1[12:10], rs2[9:7], rd[6:4], rsvd[3:0]}
   function automatic op_t get_op(input logic [INSTR_W-1:0] w);
      return op_t'(w[15:13]);
   endfunction

   function automatic logic [2:0] get_rs1(input logic [INSTR_W-1:0] w);
      return w[12:10];
   endfunction

   function automatic logic [2:0] get_rs2(input logic [INSTR_W-1:0] w);
      return w[9:7];
   endfunction

   function automatic logic [2:0] get_rd(input logic [INSTR_W-1:0] w);
      return w[6:4];
   endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Shift pipe of in-flight destination registers; flags RAW hazards for the
// word about to issue and reports whether results are still in flight.
module issue_scoreboard #(
   parameter int WB_LAT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ins_v_i,
   input  logic [2:0] ins_rd_i,
   input  logic [2:0] rs1_i,
   input  logic [2:0] rs2_i,
   output logic       hazard_o,
   output logic       pending_o
);

   localparam int   N  = (WB_LAT > 1) ? WB_LAT - 1 : 0;
   localparam int   NE = (N > 0) ? N : 1;
   // With WB_LAT=1 a single entry is kept but never marked valid.
   localparam logic EN = (N > 0);

   logic [NE-1:0] v_q;
   logic [2:0]    rd_q [NE];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int i = 0; i < NE; i++) rd_q[i] <= '0;
      end else begin
         v_q[0]  <= ins_v_i & EN;
         rd_q[0] <= ins_rd_i;
         for (int i = 1; i < NE; i++) begin
            v_q[i]  <= v_q[i-1];
            rd_q[i] <= rd_q[i-1];
         end
      end
   end

   // pending ignores the oldest entry: it retires at the coming edge.
   always_comb begin
      hazard_o  = 1'b0;
      pending_o = 1'b0;
      for (int i = 0; i < NE; i++) begin
         if (v_q[i] && (rd_q[i] == rs1_i || rd_q[i] == rs2_i)) hazard_o = 1'b1;
      end
      for (int i = 0; i < NE - 1; i++) begin
         if (v_q[i]) pending_o = 1'b1;
      end
   end

endmodule

// File: rtl/shader_instr_issuer.sv
// Program store, program counter and run FSM feeding shader_core over valid/ready,
// with bubbles inserted for read-after-write hazards.
//
//  state    | meaning
//  ST_IDLE  | waiting for start; store loadable
//  ST_RUN   | presenting store[pc], transferring on ready
//  ST_DRAIN | last issue done (or HALT seen); waiting for results to land
//  ST_DONE  | one-cycle done pulse
module shader_instr_issuer
   import shader_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int WB_LAT = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_en,
   input  logic [AW-1:0]      load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic [AW:0]        prog_len,
   input  logic               start,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               core_ready,
   output logic               busy,
   output logic               done,
   output logic [AW-1:0]      pc,
   output logic [15:0]        issued_cnt
);

   logic [INSTR_W-1:0] store_q [DEPTH];
   state_t             state_q;
   logic [AW-1:0]      pc_q;
   logic [AW:0]        len_q;
   logic [15:0]        cnt_q;
   logic               hold_q;

   logic [INSTR_W-1:0] cur_w;
   logic               is_halt;
   logic               hazard;
   logic               pending;
   logic               valid;
   logic               xfer;
   logic               last;

   assign cur_w   = store_q[pc_q];
   assign is_halt = (get_op(cur_w) == OP_HALT);
   // Once offered, a word stays valid until taken regardless of the hazard check.
   assign valid   = (state_q == ST_RUN) && !is_halt && (hold_q || !hazard);
   assign xfer    = valid && core_ready;
   assign last    = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

   issue_scoreboard #(.WB_LAT(WB_LAT)) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .ins_v_i   (xfer),
      .ins_rd_i  (get_rd(cur_w)),
      .rs1_i     (get_rs1(cur_w)),
      .rs2_i     (get_rs2(cur_w)),
      .hazard_o  (hazard),
      .pending_o (pending)
   );

   // Store is deliberately not reset.
   always_ff @(posedge clk) begin
      if (load_en && state_q == ST_IDLE) store_q[load_addr] <= load_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         hold_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               hold_q <= 1'b0;
               if (start) begin
                  len_q   <= prog_len;
                  pc_q    <= '0;
                  cnt_q   <= '0;
                  state_q <= (prog_len == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               hold_q <= valid && !core_ready;
               if (xfer) begin
                  pc_q <= pc_q + AW'(1);
                  if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                  if (last) state_q <= ST_DRAIN;
               end else if (is_halt) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               hold_q <= 1'b0;
               if (!pending) state_q <= ST_DONE;
            end
            default: begin
               hold_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign instr       = (state_q == ST_RUN) ? cur_w : '0;
   assign instr_valid = valid;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign pc          = pc_q;
   assign issued_cnt  = cnt_q;

endmodule

// File: tb/tb_shader_instr_issuer.sv
// Bench for shader_instr_issuer: WB_LAT=2 and WB_LAT=1 instances share stimulus;
// a per-cycle reference derived from issue times and result-ready times checks one at a time.
module tb_shader_instr_issuer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_en = 1'b0;
   logic [3:0]  load_addr = '0;
   logic [15:0] load_data = '0;
   logic [4:0]  prog_len = '0;
   logic        start = 1'b0;
   logic        core_ready = 1'b1;

   logic [15:0] a_instr, b_instr, o_instr;
   logic        a_valid, b_valid, o_valid;
   logic        a_busy, b_busy, o_busy;
   logic        a_done, b_done, o_done;
   logic [3:0]  a_pc, b_pc, o_pc;
   logic [15:0] a_cnt, b_cnt, o_cnt;

   int sel = 0;
   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] mem [16];

   always #5 clk = ~clk;

   shader_instr_issuer #(.DEPTH(16), .WB_LAT(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .prog_len(prog_len), .start(start),
      .instr(a_instr), .instr_valid(a_valid), .core_ready(core_ready),
      .busy(a_busy), .done(a_done), .pc(a_pc), .issued_cnt(a_cnt));

   shader_instr_issuer #(.DEPTH(16), .WB_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .prog_len(prog_len), .start(start),
      .instr(b_instr), .instr_valid(b_valid), .core_ready(core_ready),
      .busy(b_busy), .done(b_done), .pc(b_pc), .issued_cnt(b_cnt));

   always_comb begin
      o_instr = (sel != 0) ? b_instr : a_instr;
      o_valid = (sel != 0) ? b_valid : a_valid;
      o_busy  = (sel != 0) ? b_busy  : a_busy;
      o_done  = (sel != 0) ? b_done  : a_done;
      o_pc    = (sel != 0) ? b_pc    : a_pc;
      o_cnt   = (sel != 0) ? b_cnt   : a_cnt;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (lat%0d) @%0t: got 0x%0h want 0x%0h", tag, (sel != 0) ? 1 : 2, $time, act, exp);
      end
   endtask

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic load_word(input int a, input logic [15:0] d);
      load_en   = 1'b1;
      load_addr = a[3:0];
      load_data = d;
      @(negedge clk);
      load_en = 1'b0;
      mem[a]  = d;
   endtask

   task automatic idle_gap();
      core_ready = 1'b1;
      repeat (40) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, o_valid, 0);
      chk({tag, "_busy"},  o_busy,  0);
      chk({tag, "_done"},  o_done,  0);
      chk({tag, "_pc"},    o_pc,    0);
      chk({tag, "_cnt"},   o_cnt,   0);
      chk({tag, "_instr"}, o_instr, 0);
   endtask

   // mode 0: ready always; 1: random ready; 2: ready low for 3 cycles while word 1 is offered
   task automatic run_prog(input int s, input int len, input int mode, input bit poke,
                           input bit ld, input logic [15:0] ldw);
      int lat, idx, last_t, dn, bp_n;
      int rdy [8];
      bit draining, ok_end, ev, r;
      logic [15:0] w;
      sel = s;
      lat = (s != 0) ? 1 : 2;
      for (int i = 0; i < 8; i++) rdy[i] = -100;
      start    = 1'b1;
      prog_len = len[4:0];
      if (ld) begin
         load_en = 1'b1; load_addr = 4'd0; load_data = ldw; mem[0] = ldw;
      end
      @(negedge clk);
      start = 1'b0; load_en = 1'b0;
      idx = 0; last_t = -100; bp_n = 0; ok_end = 0;
      draining = (len == 0);
      dn = 0;
      for (int t = 0; t < 400; t++) begin
         ev = 1'b0;
         if (!draining) begin
            w = mem[idx];
            chk("instr", o_instr, w);
            chk("pc", o_pc, idx);
            if (w[15:13] == 3'b111) begin
               draining = 1'b1;
               dn = imax(t + 2, last_t + lat);
            end else begin
               ev = (t >= rdy[w[12:10]]) && (t >= rdy[w[9:7]]);
            end
         end
         chk("valid", o_valid, ev);
         chk("cnt", o_cnt, idx);
         chk("done", o_done, draining && t == dn);
         chk("busy", o_busy, !(draining && t > dn));
         if (draining && t > dn) begin
            ok_end = 1'b1;
            break;
         end
         case (mode)
            0:       r = 1'b1;
            1:       r = ($urandom_range(0, 2) != 0);
            default: begin
               r = !(idx == 1 && bp_n < 3);
               if (!r) bp_n++;
            end
         endcase
         core_ready = r;
         if (poke && t == 1) begin
            start = 1'b1; load_en = 1'b1; load_addr = 4'd0; load_data = 16'hFFFF;
         end else if (poke && t == 2) begin
            start = 1'b0; load_en = 1'b0;
         end
         if (ev && r) begin
            rdy[w[6:4]] = t + lat;
            idx++;
            last_t = t;
            if (idx == len) begin
               draining = 1'b1;
               dn = imax(t + 2, t + lat);
            end
         end
         @(negedge clk);
      end
      chk("run_end", ok_end, 1);
      start = 1'b0; load_en = 1'b0;
      idle_gap();
   endtask

   initial begin
      int len;
      logic [15:0] w;
      repeat (2) @(negedge clk);
      sel = 0; check_zero("rst");
      sel = 1; check_zero("rst");
      rst_n = 1'b1;
      @(negedge clk);

      load_word(0, 16'h00A1); load_word(1, 16'h20B1); load_word(2, 16'h40C1);
      load_word(3, 16'h60D1); load_word(4, 16'h80E1); load_word(5, 16'hA0F1);
      run_prog(0, 6, 0, 1'b1, 1'b0, 16'h0);
      run_prog(0, 6, 0, 1'b0, 1'b0, 16'h0);
      run_prog(0, 6, 2, 1'b0, 1'b0, 16'h0);
      run_prog(1, 6, 0, 1'b0, 1'b0, 16'h0);

      load_word(0, 16'h00A1); load_word(1, 16'h08B1);
      run_prog(0, 2, 0, 1'b0, 1'b0, 16'h0);
      run_prog(1, 2, 0, 1'b0, 1'b0, 16'h0);

      load_word(0, 16'h00A1); load_word(1, 16'hE000); load_word(2, 16'h20B1);
      run_prog(0, 3, 0, 1'b0, 1'b0, 16'h0);
      run_prog(1, 3, 1, 1'b0, 1'b0, 16'h0);

      run_prog(0, 0, 0, 1'b0, 1'b0, 16'h0);
      run_prog(0, 2, 0, 1'b0, 1'b1, 16'hC2A5);

      load_word(0, 16'h00A1); load_word(1, 16'h20B1); load_word(2, 16'h40C1);
      load_word(3, 16'h60D1); load_word(4, 16'h80E1); load_word(5, 16'hA0F1);
      sel = 0;
      core_ready = 1'b1;
      start = 1'b1; prog_len = 5'd6;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20 && o_pc != 4'd3; i++) @(negedge clk);
      chk("pc_at_rst", o_pc, 3);
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_prog(0, 6, 0, 1'b0, 1'b0, 16'h0);

      for (int k = 0; k < 12; k++) begin
         len = $urandom_range(1, 16);
         for (int a = 0; a < len; a++) begin
            w = 16'($urandom);
            if (w[15:13] == 3'b111 && $urandom_range(0, 3) != 0) w[15:13] = 3'b110;
            load_word(a, w);
         end
         run_prog(k % 2, len, 1, 1'b0, 1'b0, 16'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
